mx_tile_sequencer: RTL and testbench

Transmitter-side sequencer for the MX block-PE operand interface. It accepts a job (beat count, precision/FP modes), pulls A/B operand beats from an upstream source, and presents them to the PE array's A/B valid/ready inputs. After the last accepted beat it drains, pulses `send_output`, and captures the 8x8 result tile and shared exponent into a held result register for a downstream consumer. It sits between the operand memory streamer and the registered PE-array wrapper.

---
 rtl/mx_pkg.sv | 21 ++
 rtl/mx_tile_sequencer_if.sv | 70 +++++++
 rtl/mx_beat_skid.sv | 36 +++
 rtl/mx_tile_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mx_tile_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mx_pkg.sv
// Shared types and widths for the MX block-PE operand sequencer.
// Beat layout in the skid stage: {a, b, exp_a, exp_b}.
package mx_pkg;

   localparam int MX_BEAT_W = 256;
   localparam int MX_TILE_W = 512;
   localparam int MX_EXP_W  = 8;
   localparam int MX_SKID_W = 2*MX_BEAT_W + 2*MX_EXP_W;

   typedef logic [1:0] mx_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_SEND,
      ST_WAIT_OUT,
      ST_HOLD
   } seq_state_t;

endpackage

// File: rtl/mx_tile_sequencer_if.sv
// Job, source, PE-operand and result bundles of the tile sequencer.
// master = the sequencer itself, slave = its surroundings.
interface mx_tile_sequencer_if #(
   parameter int KW = 8
);
   import mx_pkg::*;

   logic                 start_i;
   logic [KW-1:0]        num_k_i;
   mx_mode_t             prec_mode_i;
   mx_mode_t             fp_mode_i;
   mx_mode_t             prec_mode_quan_i;
   mx_mode_t             fp_mode_quan_i;
   logic                 busy_o;

   logic                 src_valid_i;
   logic                 src_ready_o;
   logic [MX_BEAT_W-1:0] src_a_i;
   logic [MX_BEAT_W-1:0] src_b_i;
   logic [MX_EXP_W-1:0]  src_exp_a_i;
   logic [MX_EXP_W-1:0]  src_exp_b_i;

   logic                 pe_a_valid_o;
   logic                 pe_b_valid_o;
   logic                 pe_a_ready_i;
   logic                 pe_b_ready_i;
   logic [MX_BEAT_W-1:0] pe_a_data_o;
   logic [MX_BEAT_W-1:0] pe_b_data_o;
   logic [MX_EXP_W-1:0]  pe_exp_a_o;
   logic [MX_EXP_W-1:0]  pe_exp_b_o;
   mx_mode_t             pe_prec_mode_o;
   mx_mode_t             pe_fp_mode_o;
   mx_mode_t             pe_prec_mode_quan_o;
   mx_mode_t             pe_fp_mode_quan_o;
   logic                 pe_send_output_o;
   logic [MX_TILE_W-1:0] pe_out_i;
   logic [MX_EXP_W-1:0]  pe_shared_exp_out_i;

   logic                 res_valid_o;
   logic                 res_ready_i;
   logic [MX_TILE_W-1:0] res_data_o;
   logic [MX_EXP_W-1:0]  res_exp_o;

   modport master (
      input  start_i, num_k_i, prec_mode_i, fp_mode_i, prec_mode_quan_i, fp_mode_quan_i,
      output busy_o,
      input  src_valid_i, src_a_i, src_b_i, src_exp_a_i, src_exp_b_i,
      output src_ready_o,
      output pe_a_valid_o, pe_b_valid_o, pe_a_data_o, pe_b_data_o, pe_exp_a_o, pe_exp_b_o,
      output pe_prec_mode_o, pe_fp_mode_o, pe_prec_mode_quan_o, pe_fp_mode_quan_o,
      output pe_send_output_o,
      input  pe_a_ready_i, pe_b_ready_i, pe_out_i, pe_shared_exp_out_i,
      output res_valid_o, res_data_o, res_exp_o,
      input  res_ready_i
   );

   modport slave (
      output start_i, num_k_i, prec_mode_i, fp_mode_i, prec_mode_quan_i, fp_mode_quan_i,
      input  busy_o,
      output src_valid_i, src_a_i, src_b_i, src_exp_a_i, src_exp_b_i,
      input  src_ready_o,
      input  pe_a_valid_o, pe_b_valid_o, pe_a_data_o, pe_b_data_o, pe_exp_a_o, pe_exp_b_o,
      input  pe_prec_mode_o, pe_fp_mode_o, pe_prec_mode_quan_o, pe_fp_mode_quan_o,
      input  pe_send_output_o,
      output pe_a_ready_i, pe_b_ready_i, pe_out_i, pe_shared_exp_out_i,
      input  res_valid_o, res_data_o, res_exp_o,
      output res_ready_i
   );

endinterface

// File: rtl/mx_beat_skid.sv
// One-entry valid/ready hold stage carrying a joint A/B operand beat.
// Accepts a new beat in the same cycle the held one retires.
module mx_beat_skid
   import mx_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MX_SKID_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [MX_SKID_W-1:0] out_data
);

   logic                 hold_full_reg;
   logic [MX_SKID_W-1:0] hold_data_reg;

   assign in_ready  = !hold_full_reg || out_ready;
   assign out_valid = hold_full_reg;
   assign out_data  = hold_data_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_full_reg <= 1'b0;
         hold_data_reg <= '0;
      end else if (in_valid && in_ready) begin
         hold_full_reg <= 1'b1;
         hold_data_reg <= in_data;
      end else if (hold_full_reg && out_ready) begin
         // data kept after retirement; only the valid drops
         hold_full_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/mx_tile_sequencer.sv
// Feeds a job of joint A/B beats to the PE array, drains, pulses
// send_output and holds the returned result tile for the consumer.
module mx_tile_sequencer
   import mx_pkg::*;
#(
   parameter int KW           = 8,
   parameter int DRAIN_CYCLES = 4,
   parameter int OUT_LATENCY  = 3
)(
   input  logic                clk_i,
   input  logic                rst_i,
   mx_tile_sequencer_if.master bus
);

   seq_state_t state_reg, state_next;
   logic [KW-1:0] beats_left_reg, beats_left_next;
   logic [KW-1:0] loaded_reg, loaded_next;
   logic [KW-1:0] num_k_reg, num_k_next;
   logic [7:0]    wait_cnt_reg, wait_cnt_next;
   logic          mode_latch, capture;

   mx_mode_t prec_mode_reg, fp_mode_reg, prec_mode_quan_reg, fp_mode_quan_reg;
   logic     send_reg, res_valid_reg, busy_reg;
   logic [MX_TILE_W-1:0] res_data_reg;
   logic [MX_EXP_W-1:0]  res_exp_reg;

   logic feed_open, src_fire, pe_fire;
   logic skid_in_valid, skid_in_ready, skid_out_valid, skid_out_ready;
   logic [MX_SKID_W-1:0] skid_in_data, skid_out_data;

   // Source is closed once every beat of the job has entered the hold stage.
   assign feed_open      = (state_reg == ST_FEED) && (loaded_reg != num_k_reg);
   assign skid_in_valid  = feed_open && bus.src_valid_i;
   assign skid_in_data   = {bus.src_a_i, bus.src_b_i, bus.src_exp_a_i, bus.src_exp_b_i};
   assign skid_out_ready = bus.pe_a_ready_i && bus.pe_b_ready_i;
   assign pe_fire        = skid_out_valid && skid_out_ready;
   assign bus.src_ready_o = feed_open && skid_in_ready;
   assign src_fire       = bus.src_valid_i && bus.src_ready_o;

   mx_beat_skid u_skid (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (skid_in_valid),
      .in_ready  (skid_in_ready),
      .in_data   (skid_in_data),
      .out_valid (skid_out_valid),
      .out_ready (skid_out_ready),
      .out_data  (skid_out_data)
   );

   assign bus.pe_a_valid_o = skid_out_valid;
   assign bus.pe_b_valid_o = skid_out_valid;
   assign bus.pe_a_data_o  = skid_out_data[MX_SKID_W-1 -: MX_BEAT_W];
   assign bus.pe_b_data_o  = skid_out_data[2*MX_EXP_W +: MX_BEAT_W];
   assign bus.pe_exp_a_o   = skid_out_data[MX_EXP_W +: MX_EXP_W];
   assign bus.pe_exp_b_o   = skid_out_data[0 +: MX_EXP_W];

   assign bus.pe_prec_mode_o      = prec_mode_reg;
   assign bus.pe_fp_mode_o        = fp_mode_reg;
   assign bus.pe_prec_mode_quan_o = prec_mode_quan_reg;
   assign bus.pe_fp_mode_quan_o   = fp_mode_quan_reg;
   assign bus.pe_send_output_o    = send_reg;
   assign bus.busy_o              = busy_reg;
   assign bus.res_valid_o         = res_valid_reg;
   assign bus.res_data_o          = res_data_reg;
   assign bus.res_exp_o           = res_exp_reg;

   always_comb begin
      state_next      = state_reg;
      beats_left_next = beats_left_reg;
      loaded_next     = loaded_reg;
      num_k_next      = num_k_reg;
      wait_cnt_next   = wait_cnt_reg;
      mode_latch      = 1'b0;
      capture         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start_i && (bus.num_k_i != '0)) begin
               mode_latch      = 1'b1;
               num_k_next      = bus.num_k_i;
               beats_left_next = bus.num_k_i;
               loaded_next     = '0;
               state_next      = ST_FEED;
            end
         end
         ST_FEED: begin
            if (src_fire) begin
               loaded_next = loaded_reg + KW'(1);
            end
            if (pe_fire) begin
               beats_left_next = beats_left_reg - KW'(1);
               if (beats_left_reg == KW'(1)) begin
                  wait_cnt_next = '0;
                  state_next    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (wait_cnt_reg == 8'(DRAIN_CYCLES - 1)) begin
               wait_cnt_next = '0;
               state_next    = ST_SEND;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         ST_SEND: begin
            wait_cnt_next = '0;
            state_next    = ST_WAIT_OUT;
         end
         ST_WAIT_OUT: begin
            if (wait_cnt_reg == 8'(OUT_LATENCY - 1)) begin
               capture       = 1'b1;
               wait_cnt_next = '0;
               state_next    = ST_HOLD;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         ST_HOLD: begin
            if (bus.res_ready_i) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so every output leaves a flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg          <= ST_IDLE;
         beats_left_reg     <= '0;
         loaded_reg         <= '0;
         num_k_reg          <= '0;
         wait_cnt_reg       <= '0;
         prec_mode_reg      <= '0;
         fp_mode_reg        <= '0;
         prec_mode_quan_reg <= '0;
         fp_mode_quan_reg   <= '0;
         send_reg           <= 1'b0;
         res_valid_reg      <= 1'b0;
         busy_reg           <= 1'b0;
         res_data_reg       <= '0;
         res_exp_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         beats_left_reg <= beats_left_next;
         loaded_reg     <= loaded_next;
         num_k_reg      <= num_k_next;
         wait_cnt_reg   <= wait_cnt_next;
         send_reg       <= (state_next == ST_SEND);
         res_valid_reg  <= (state_next == ST_HOLD);
         busy_reg       <= (state_next != ST_IDLE);
         if (mode_latch) begin
            prec_mode_reg      <= bus.prec_mode_i;
            fp_mode_reg        <= bus.fp_mode_i;
            prec_mode_quan_reg <= bus.prec_mode_quan_i;
            fp_mode_quan_reg   <= bus.fp_mode_quan_i;
         end
         if (capture) begin
            res_data_reg <= bus.pe_out_i;
            res_exp_reg  <= bus.pe_shared_exp_out_i;
         end
      end
   end

endmodule

// File: tb/tb_mx_tile_sequencer.sv
// Scoreboard bench for mx_tile_sequencer: beats and result tiles are queued
// when driven and checked when the PE side fires or the result appears.
module tb_mx_tile_sequencer;
   import mx_pkg::*;

   localparam int KW = 8;
   typedef logic [MX_SKID_W-1:0]          beat_t;
   typedef logic [MX_TILE_W+MX_EXP_W-1:0] tile_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   mx_tile_sequencer_if #(.KW(KW)) bus();

   mx_tile_sequencer #(.KW(KW), .DRAIN_CYCLES(4), .OUT_LATENCY(3)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   beat_t src_beats[$];
   beat_t beat_q[$];
   tile_t res_q[$];
   int    src_idx = 0;

   logic          a_rdy = 1'b1, b_rdy = 1'b1, res_rdy = 1'b1, src_en = 1'b1;
   logic          start_req = 1'b0;
   logic [KW-1:0] num_k_req = '0;

   int    fires = 0, first_fire_cyc = 0, last_fire_cyc = 0, send_cyc = 0;
   bit    send_seen = 0, res_done = 0, prev_res_valid = 0;
   tile_t cur_tile = '0;
   tile_t held_res = '0;

   // One clock: drive at posedge+1, sample and score at negedge.
   task automatic tick();
      beat_t got, exp_b;
      tile_t exp_r;
      logic [MX_TILE_W-1:0] t;
      @(posedge clk_i);
      #1;
      cyc++;
      bus.start_i      = start_req;
      bus.num_k_i      = num_k_req;
      start_req        = 1'b0;
      bus.pe_a_ready_i = a_rdy;
      bus.pe_b_ready_i = b_rdy;
      bus.res_ready_i  = res_rdy;
      bus.src_valid_i  = src_en && (src_idx < src_beats.size());
      if (bus.src_valid_i)
         {bus.src_a_i, bus.src_b_i, bus.src_exp_a_i, bus.src_exp_b_i} = src_beats[src_idx];
      else
         {bus.src_a_i, bus.src_b_i, bus.src_exp_a_i, bus.src_exp_b_i} = '0;
      if (send_seen && cyc == send_cyc + 3)
         {bus.pe_out_i, bus.pe_shared_exp_out_i} = cur_tile;
      else
         {bus.pe_out_i, bus.pe_shared_exp_out_i} = ~cur_tile;
      @(negedge clk_i);

      got = {bus.pe_a_data_o, bus.pe_b_data_o, bus.pe_exp_a_o, bus.pe_exp_b_o};
      if (bus.pe_a_valid_o && bus.pe_a_ready_i && bus.pe_b_valid_o && bus.pe_b_ready_i) begin
         total++;
         if (beat_q.size() == 0) begin
            bad++;
            $display("FAIL beat_extra: fire at cycle %0d with no beat outstanding, got %h", cyc, got);
         end else begin
            exp_b = beat_q.pop_front();
            if (got !== exp_b) begin
               bad++;
               $display("FAIL beat_data: got %h expected %h", got, exp_b);
            end
         end
         if (fires == 0) first_fire_cyc = cyc;
         last_fire_cyc = cyc;
         fires++;
      end
      if (bus.src_valid_i && bus.src_ready_o) begin
         beat_q.push_back(src_beats[src_idx]);
         src_idx++;
      end

      if (bus.pe_send_output_o) begin
         total++;
         if (cyc !== last_fire_cyc + 5) begin
            bad++;
            $display("FAIL send_timing: send at cycle %0d expected %0d", cyc, last_fire_cyc + 5);
         end
         send_seen = 1;
         send_cyc  = cyc;
         for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
         cur_tile = {t, 8'($urandom)};
         res_q.push_back(cur_tile);
      end

      if (bus.res_valid_o && !prev_res_valid) begin
         total++;
         if (res_q.size() == 0) begin
            bad++;
            $display("FAIL res_extra: result at cycle %0d with none expected", cyc);
         end else begin
            exp_r    = res_q.pop_front();
            held_res = exp_r;
            if ({bus.res_data_o, bus.res_exp_o} !== exp_r) begin
               bad++;
               $display("FAIL res_data: got exp %h expected exp %h", bus.res_exp_o, exp_r[7:0]);
            end
         end
         total++;
         if (cyc !== send_cyc + 4) begin
            bad++;
            $display("FAIL res_timing: res_valid at cycle %0d expected %0d", cyc, send_cyc + 4);
         end
         res_done = 1;
      end
      prev_res_valid = bus.res_valid_o;
   endtask

   task automatic load_beats(input int n, input logic [7:0] seed);
      logic [7:0] p;
      src_beats.delete();
      src_idx   = 0;
      fires     = 0;
      send_seen = 0;
      res_done  = 0;
      for (int i = 0; i < n; i++) begin
         p = 8'(seed * (i + 1));
         src_beats.push_back({{32{p}}, {32{~p}}, p, 8'(p + 8'd1)});
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      total++;
      if ({bus.busy_o, bus.src_ready_o, bus.pe_a_valid_o, bus.pe_b_valid_o,
           bus.pe_send_output_o, bus.res_valid_o} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b required 000000", {bus.busy_o, bus.src_ready_o,
                  bus.pe_a_valid_o, bus.pe_b_valid_o, bus.pe_send_output_o, bus.res_valid_o});
      end
      total++;
      if ({bus.pe_a_data_o, bus.pe_exp_a_o, bus.res_data_o, bus.res_exp_o, bus.pe_prec_mode_o} !== '0) begin
         bad++;
         $display("FAIL reset_data: data/exp/mode outputs nonzero, pe_exp_a=%h res_exp=%h",
                  bus.pe_exp_a_o, bus.res_exp_o);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic test_basic();
      load_beats(3, 8'h11);
      a_rdy = 1; b_rdy = 1; src_en = 1; res_rdy = 1;
      bus.prec_mode_i = 2'b01; bus.fp_mode_i = 2'b10;
      bus.prec_mode_quan_i = 2'b11; bus.fp_mode_quan_i = 2'b01;
      start_req = 1; num_k_req = 3;
      tick();
      total++;
      if (bus.busy_o !== 1'b0) begin
         bad++; $display("FAIL basic_busy_early: got %b required 0", bus.busy_o);
      end
      tick();
      total++;
      if ({bus.busy_o, bus.src_ready_o} !== 2'b11) begin
         bad++; $display("FAIL basic_feed_entry: busy,src_ready got %b required 11", {bus.busy_o, bus.src_ready_o});
      end
      total++;
      if ({bus.pe_prec_mode_o, bus.pe_fp_mode_o, bus.pe_prec_mode_quan_o, bus.pe_fp_mode_quan_o} !== 8'b01101101) begin
         bad++; $display("FAIL basic_modes: got %b required 01101101",
                         {bus.pe_prec_mode_o, bus.pe_fp_mode_o, bus.pe_prec_mode_quan_o, bus.pe_fp_mode_quan_o});
      end
      for (int i = 0; i < 60 && !res_done; i++) tick();
      total++;
      if (!res_done) begin
         bad++; $display("FAIL basic_timeout: no result within 60 cycles");
      end
      total++;
      if (fires !== 3 || last_fire_cyc - first_fire_cyc !== 2) begin
         bad++; $display("FAIL basic_throughput: fires=%0d span=%0d required 3 and 2", fires, last_fire_cyc - first_fire_cyc);
      end
      tick();
      total++;
      if ({bus.busy_o, bus.res_valid_o} !== 2'b00) begin
         bad++; $display("FAIL basic_idle: busy,res_valid got %b required 00", {bus.busy_o, bus.res_valid_o});
      end
   endtask

   task automatic test_stall();
      load_beats(3, 8'h11);
      a_rdy = 1; b_rdy = 1; res_rdy = 1;
      start_req = 1; num_k_req = 3;
      tick();
      for (int i = 0; i < 20 && fires < 1; i++) tick();
      // A stalls while B stays ready; a second start arrives mid-job
      a_rdy = 0; b_rdy = 1;
      start_req = 1; num_k_req = 5;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (bus.pe_a_valid_o !== 1'b1 || bus.pe_a_data_o !== {32{8'h22}}) begin
            bad++; $display("FAIL stall_hold: valid=%b a_data=%h required 1 and 22..", bus.pe_a_valid_o, bus.pe_a_data_o);
         end
         total++;
         if (bus.src_ready_o !== 1'b0) begin
            bad++; $display("FAIL stall_src_ready: got %b required 0", bus.src_ready_o);
         end
         total++;
         if (fires !== 1) begin
            bad++; $display("FAIL stall_fire: fires=%0d required 1", fires);
         end
      end
      a_rdy = 1;
      for (int i = 0; i < 60 && !res_done; i++) tick();
      total++;
      if (!res_done || fires !== 3 || beat_q.size() !== 0) begin
         bad++; $display("FAIL stall_complete: done=%0d fires=%0d pending=%0d required 1,3,0", res_done, fires, beat_q.size());
      end
      tick();
   endtask

   task automatic test_zero_k();
      load_beats(0, 8'h00);
      start_req = 1; num_k_req = 0;
      tick();
      tick();
      tick();
      total++;
      if ({bus.busy_o, bus.src_ready_o, bus.pe_a_valid_o} !== 3'b000) begin
         bad++; $display("FAIL zero_k: busy,src_ready,pe_valid got %b required 000",
                         {bus.busy_o, bus.src_ready_o, bus.pe_a_valid_o});
      end
   endtask

   task automatic test_res_hold();
      load_beats(1, 8'h5a);
      res_rdy = 0;
      start_req = 1; num_k_req = 1;
      tick();
      for (int i = 0; i < 60 && !res_done; i++) tick();
      total++;
      if (!res_done) begin
         bad++; $display("FAIL hold_timeout: no result within 60 cycles");
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (bus.res_valid_o !== 1'b1 || {bus.res_data_o, bus.res_exp_o} !== held_res) begin
            bad++; $display("FAIL hold_stable: res_valid=%b exp=%h required 1 and %h", bus.res_valid_o, bus.res_exp_o, held_res[7:0]);
         end
      end
      load_beats(1, 8'h3c);
      res_rdy = 1;
      start_req = 1; num_k_req = 1;   // same cycle as release: must be ignored
      tick();
      start_req = 1; num_k_req = 1;
      tick();
      total++;
      if ({bus.busy_o, bus.res_valid_o} !== 2'b00) begin
         bad++; $display("FAIL hold_release: busy,res_valid got %b required 00", {bus.busy_o, bus.res_valid_o});
      end
      tick();
      total++;
      if (bus.busy_o !== 1'b1) begin
         bad++; $display("FAIL hold_restart: busy got %b required 1", bus.busy_o);
      end
      for (int i = 0; i < 60 && !res_done; i++) tick();
      total++;
      if (!res_done || fires !== 1) begin
         bad++; $display("FAIL hold_second_job: done=%0d fires=%0d required 1,1", res_done, fires);
      end
      tick();
   endtask

   task automatic test_async_reset();
      load_beats(3, 8'h77);
      a_rdy = 0; b_rdy = 1; res_rdy = 1;
      start_req = 1; num_k_req = 3;
      tick();
      repeat (3) tick();
      total++;
      if (bus.pe_a_valid_o !== 1'b1 || bus.pe_exp_a_o !== 8'h77) begin
         bad++; $display("FAIL areset_pending: valid=%b exp_a=%h required 1 and 77", bus.pe_a_valid_o, bus.pe_exp_a_o);
      end
      #2 rst_i = 1'b1;
      #1;
      total++;
      if ({bus.busy_o, bus.src_ready_o, bus.pe_a_valid_o, bus.pe_b_valid_o} !== 4'b0000) begin
         bad++; $display("FAIL areset_ctrl: busy,src_ready,valids got %b required 0000",
                         {bus.busy_o, bus.src_ready_o, bus.pe_a_valid_o, bus.pe_b_valid_o});
      end
      total++;
      if ({bus.pe_a_data_o, bus.pe_exp_a_o, bus.pe_prec_mode_o, bus.pe_fp_mode_o} !== '0) begin
         bad++; $display("FAIL areset_data: exp_a=%h prec=%b fp=%b required all 0", bus.pe_exp_a_o, bus.pe_prec_mode_o, bus.pe_fp_mode_o);
      end
      beat_q.delete();
      res_q.delete();
      prev_res_valid = 0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      load_beats(2, 8'h44);
      a_rdy = 1;
      start_req = 1; num_k_req = 2;
      tick();
      for (int i = 0; i < 60 && !res_done; i++) tick();
      total++;
      if (!res_done || fires !== 2 || beat_q.size() !== 0) begin
         bad++; $display("FAIL areset_fresh_job: done=%0d fires=%0d pending=%0d required 1,2,0", res_done, fires, beat_q.size());
      end
      tick();
   endtask

   initial begin
      bus.start_i = 0; bus.num_k_i = '0;
      bus.prec_mode_i = '0; bus.fp_mode_i = '0; bus.prec_mode_quan_i = '0; bus.fp_mode_quan_i = '0;
      bus.src_valid_i = 0; bus.src_a_i = '0; bus.src_b_i = '0; bus.src_exp_a_i = '0; bus.src_exp_b_i = '0;
      bus.pe_a_ready_i = 0; bus.pe_b_ready_i = 0; bus.pe_out_i = '0; bus.pe_shared_exp_out_i = '0;
      bus.res_ready_i = 0;
      test_reset();
      test_basic();
      test_stall();
      test_zero_k();
      test_res_hold();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
